ysyx_22040931_regfile_sb: RTL and testbench

- Parametrised successor to the single-write/dual-read GPR file for the pipelined core: NR read ports, NW write ports, configurable width/depth.
- Adds a per-register pending-write scoreboard (in-flight counters) so decode can detect RAW hazards and stall issue.
- Sits between decode/issue (read + issue) and writeback (write + retire).

---
 rtl/ysyx_22040931_regfile_sb_if.sv | 32 +++
 rtl/ysyx_22040931_regfile_sb.sv | 107 ++++++++++
 tb/tb_ysyx_22040931_regfile_sb.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040931_regfile_sb_if.sv
// Register-file bus: read ports, write/retire ports and the issue handshake
// between decode/issue (master) and the scoreboarded register file (slave).
interface ysyx_22040931_regfile_sb_if #(
    parameter int DW = 64,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 2
);
    logic [NR-1:0]    r_ena;
    logic [NR*AW-1:0] r_addr;
    logic [NR*DW-1:0] r_data;
    logic [NR-1:0]    r_busy;

    logic [NW-1:0]    w_ena;
    logic [NW*AW-1:0] w_addr;
    logic [NW*DW-1:0] w_data;
    logic [NW-1:0]    w_retire;

    logic             iss_valid;
    logic [AW-1:0]    iss_rd;
    logic             iss_ready;

    modport master (
        output r_ena, r_addr, w_ena, w_addr, w_data, w_retire, iss_valid, iss_rd,
        input  r_data, r_busy, iss_ready
    );

    modport slave (
        input  r_ena, r_addr, w_ena, w_addr, w_data, w_retire, iss_valid, iss_rd,
        output r_data, r_busy, iss_ready
    );
endinterface

// File: rtl/ysyx_22040931_regfile_sb.sv
// Multi-port GPR file with write bypass and a per-register pending-write
// scoreboard. Issue allocates a pending entry, a retiring write frees one.
// Entry 0 is hardwired to zero and never tracked.
module ysyx_22040931_regfile_sb #(
    parameter int DW = 64,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 2,
    parameter int CW = 2
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_22040931_regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int DCW   = $clog2(NW + 1);
    localparam int SW    = CW + DCW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0]    regs    [DEPTH];
    logic [CW-1:0]    cnt     [DEPTH];
    logic [CW-1:0]    cnt_nxt [DEPTH];
    logic [DCW-1:0]   dec     [DEPTH];
    logic             underflow;
    logic             iss_ready;
    logic             iss_fire;
    logic [NR*DW-1:0] r_data;
    logic [NR-1:0]    r_busy;
    logic [AW-1:0]    ra;
    logic [SW-1:0]    sum;

    // Count retiring writes per register this cycle; x0 never counts.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) dec[i] = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            if (bus.w_ena[j] && bus.w_retire[j] && (bus.w_addr[j*AW +: AW] != '0))
                dec[bus.w_addr[j*AW +: AW]] = dec[bus.w_addr[j*AW +: AW]] + DCW'(1);
        end
    end

    // Issue acceptance from counter state only, so iss_valid never loops back.
    always_comb begin
        iss_ready = 1'b0;
        if (reset)
            iss_ready = (bus.iss_rd == '0) || (cnt[bus.iss_rd] != CNT_MAX) ||
                        (dec[bus.iss_rd] != '0);
    end

    assign iss_fire = bus.iss_valid && iss_ready && (bus.iss_rd != '0);

    // Next counter value: plus accepted issue, minus retires, floored at zero.
    always_comb begin
        underflow = 1'b0;
        sum       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sum = SW'(cnt[i]) + SW'(iss_fire && (bus.iss_rd == AW'(i)));
            if (sum < SW'(dec[i])) begin
                cnt_nxt[i] = '0;
                underflow  = 1'b1;
            end else begin
                cnt_nxt[i] = CW'(sum - SW'(dec[i]));
            end
        end
    end

    // Storage and scoreboard state; ascending port order lets the highest index win.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (bus.w_ena[j] && (bus.w_addr[j*AW +: AW] != '0))
                    regs[bus.w_addr[j*AW +: AW]] <= bus.w_data[j*DW +: DW];
            end
            for (int unsigned i = 0; i < DEPTH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Read ports: bypass the highest matching write, else storage; busy nets out retires.
    always_comb begin
        r_data = '0;
        r_busy = '0;
        ra     = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            ra = bus.r_addr[k*AW +: AW];
            if (reset && bus.r_ena[k]) begin
                r_data[k*DW +: DW] = regs[ra];
                for (int unsigned j = 0; j < NW; j++) begin
                    if (bus.w_ena[j] && (bus.w_addr[j*AW +: AW] == ra) && (ra != '0))
                        r_data[k*DW +: DW] = bus.w_data[j*DW +: DW];
                end
                r_busy[k] = SW'(cnt[ra]) > SW'(dec[ra]);
            end
        end
    end

    assign bus.r_data    = r_data;
    assign bus.r_busy    = r_busy;
    assign bus.iss_ready = iss_ready;

    // Retiring more writes than were issued is a protocol error upstream.
    a_no_underflow: assert property (@(posedge clock) disable iff (!reset) !underflow);

endmodule

// File: tb/tb_ysyx_22040931_regfile_sb.sv
// Self-checking bench for the scoreboarded register file. Expected port-0
// read results are queued as stimulus is driven and popped when sampled.
module tb_ysyx_22040931_regfile_sb;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [63:0] data;
        logic        busy;
    } exp_t;
    exp_t sbq[$];

    ysyx_22040931_regfile_sb_if #(.DW(64), .AW(5), .NR(2), .NW(2)) bus ();

    ysyx_22040931_regfile_sb #(.DW(64), .AW(5), .NR(2), .NW(2), .CW(2)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic idle();
        bus.r_ena     = '0;
        bus.r_addr    = '0;
        bus.w_ena     = '0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.w_retire  = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [63:0] d, input logic ret);
        bus.w_ena[j]        = 1'b1;
        bus.w_addr[j*5 +: 5]   = a;
        bus.w_data[j*64 +: 64] = d;
        bus.w_retire[j]     = ret;
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        bus.r_ena[k]         = 1'b1;
        bus.r_addr[k*5 +: 5] = a;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        reset = 1'b0;
        rd(0, 5'd5);
        rd(1, 5'd0);
        bus.iss_rd = 5'd5;
        repeat (3) @(negedge clock);
        #1;
        tests++;
        if (bus.r_data !== '0 || bus.r_busy !== '0) begin
            $display("FAIL rst_outputs: got data=%h busy=%b, want 0/0", bus.r_data, bus.r_busy);
            fails++;
        end
        tests++;
        if (bus.iss_ready !== 1'b0) begin
            $display("FAIL rst_ready: got %b want 0", bus.iss_ready);
            fails++;
        end
        @(negedge clock);
        reset = 1'b1;
        idle();
        wr(0, 5'd0, 64'hDEAD, 1'b0);
        rd(0, 5'd0);
        rd(1, 5'd5);
        bus.iss_rd = 5'd5;
        sbq.push_back('{64'h0, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL x0_bypass: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        tests++;
        if ({bus.r_busy[1], bus.r_data[127:64]} !== 65'h0) begin
            $display("FAIL x5_after_rst: got data=%h busy=%b want 0/0", bus.r_data[127:64], bus.r_busy[1]);
            fails++;
        end
        tests++;
        if (bus.iss_ready !== 1'b1) begin
            $display("FAIL ready_after_rst: got %b want 1", bus.iss_ready);
            fails++;
        end
        @(negedge clock);
        idle();
        rd(0, 5'd0);
        sbq.push_back('{64'h0, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL x0_storage: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
    endtask

    task automatic test_write_priority();
        exp_t e;
        @(negedge clock);
        idle();
        wr(0, 5'd3, 64'h11, 1'b0);
        wr(1, 5'd3, 64'h22, 1'b0);
        rd(0, 5'd3);
        sbq.push_back('{64'h22, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL prio_bypass: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        rd(0, 5'd3);
        rd(1, 5'd3);
        sbq.push_back('{64'h22, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL prio_storage: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        tests++;
        if (bus.r_data[127:64] !== 64'h22) begin
            $display("FAIL prio_storage_p1: got %h want %h", bus.r_data[127:64], 64'h22);
            fails++;
        end
        @(negedge clock);
        idle();
        wr(0, 5'd3, 64'h33, 1'b0);
        rd(1, 5'd3);
        #1;
        tests++;
        if (bus.r_data[127:64] !== 64'h33) begin
            $display("FAIL low_port_bypass: got %h want %h", bus.r_data[127:64], 64'h33);
            fails++;
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            idle();
            bus.iss_valid = 1'b1;
            bus.iss_rd    = 5'd7;
            #1;
            tests++;
            if (bus.iss_ready !== 1'b1) begin
                $display("FAIL sb_issue%0d: ready got %b want 1", n, bus.iss_ready);
                fails++;
            end
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            idle();
            wr(0, 5'd7, 64'h70 + 64'(n), 1'b1);
            rd(0, 5'd7);
            sbq.push_back('{64'h70 + 64'(n), (n < 2)});
            #1;
            e = sbq.pop_front();
            tests++;
            if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
                $display("FAIL sb_retire%0d: got data=%h busy=%b want data=%h busy=%b",
                         n, bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
                fails++;
            end
        end
        @(negedge clock);
        idle();
        rd(0, 5'd7);
        sbq.push_back('{64'h72, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL sb_drained: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            idle();
            bus.iss_valid = 1'b1;
            bus.iss_rd    = 5'd9;
        end
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        tests++;
        if (bus.iss_ready !== 1'b0) begin
            $display("FAIL sat_block: ready got %b want 0", bus.iss_ready);
            fails++;
        end
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        wr(0, 5'd9, 64'h90, 1'b1);
        rd(0, 5'd9);
        sbq.push_back('{64'h90, 1'b1});
        #1;
        tests++;
        if (bus.iss_ready !== 1'b1) begin
            $display("FAIL sat_retire_ready: ready got %b want 1", bus.iss_ready);
            fails++;
        end
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL sat_retire_read: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        tests++;
        if (bus.iss_ready !== 1'b0) begin
            $display("FAIL sat_still_full: ready got %b want 0", bus.iss_ready);
            fails++;
        end
        @(negedge clock);
        idle();
        wr(0, 5'd9, 64'h91, 1'b1);
        wr(1, 5'd9, 64'h92, 1'b1);
        rd(0, 5'd9);
        sbq.push_back('{64'h92, 1'b1});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL sat_dual_retire: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        wr(0, 5'd9, 64'h93, 1'b1);
        rd(0, 5'd9);
        sbq.push_back('{64'h93, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL sat_last_retire: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd4;
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd4;
        wr(0, 5'd4, 64'h55, 1'b1);
        rd(0, 5'd4);
        sbq.push_back('{64'h55, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL simul_read: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        rd(0, 5'd4);
        sbq.push_back('{64'h55, 1'b1});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL simul_count_kept: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        wr(0, 5'd4, 64'h56, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd6;
        rd(0, 5'd6);
        sbq.push_back('{64'h0, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL b2b_same_cycle: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        @(negedge clock);
        idle();
        rd(0, 5'd6);
        sbq.push_back('{64'h0, 1'b1});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL b2b_next_cycle: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd2;
        wr(0, 5'd2, 64'h77, 1'b0);
        @(negedge clock);
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd2;
        @(negedge clock);
        idle();
        rd(0, 5'd2);
        bus.iss_rd = 5'd2;
        wr(1, 5'd5, 64'hAB, 1'b0);
        sbq.push_back('{64'h77, 1'b1});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL pre_reset_read: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        #1;
        reset = 1'b0;
        #1;
        tests++;
        if (bus.r_data !== '0 || bus.r_busy !== '0 || bus.iss_ready !== 1'b0) begin
            $display("FAIL async_reset_out: got data=%h busy=%b ready=%b want 0/0/0",
                     bus.r_data, bus.r_busy, bus.iss_ready);
            fails++;
        end
        @(negedge clock);
        reset = 1'b1;
        idle();
        rd(0, 5'd2);
        rd(1, 5'd5);
        bus.iss_rd = 5'd2;
        sbq.push_back('{64'h0, 1'b0});
        #1;
        e = sbq.pop_front();
        tests++;
        if ({bus.r_busy[0], bus.r_data[63:0]} !== {e.busy, e.data}) begin
            $display("FAIL post_reset_x2: got data=%h busy=%b want data=%h busy=%b",
                     bus.r_data[63:0], bus.r_busy[0], e.data, e.busy);
            fails++;
        end
        tests++;
        if ({bus.r_busy[1], bus.r_data[127:64]} !== 65'h0) begin
            $display("FAIL post_reset_x5: got data=%h busy=%b want 0/0", bus.r_data[127:64], bus.r_busy[1]);
            fails++;
        end
        tests++;
        if (bus.iss_ready !== 1'b1) begin
            $display("FAIL post_reset_ready: got %b want 1", bus.iss_ready);
            fails++;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_write_priority();
        test_scoreboard();
        test_saturation();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        @(negedge clock);
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
